// File: rtl/wb_multi_arbiter_pkg.sv
// Shared definitions for the multi-channel Wishbone arbiter.
//   arb_state_t  : arbiter FSM states (RMW states used only with WB_RMW_EN)
//   WB_SEL_ALL   : all-ones byte select, sliced to SEL_W by users
//   STOP/NO_STOP : stall request levels
//   RST_ENABLE   : active reset level
package wb_multi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUS    = 3'd1,
    ST_DONE   = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4
  } arb_state_t;

  localparam int           MAX_SEL_W  = 64;
  localparam logic [MAX_SEL_W-1:0] WB_SEL_ALL = '1;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

endpackage

// File: rtl/wb_multi_arbiter_prio_enc.sv
// Fixed-priority encoder: highest-index asserted request wins.
//   req   : request vector (N bits)
//   idx   : index of the winning request
//   valid : at least one request asserted
module wb_prio_enc
  import wb_multi_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_multi_arbiter.sv
// Arbitrates NUM_CH requestor channels (0 = IF, NUM_CH-1 = MEM, higher index
// wins) onto one registered Wishbone classic master port.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   flush_i               : pipeline flush; cancels an in-flight channel-0 fetch
//   req_ce/we/addr/data/sel_i : packed per-channel requests
//   rsp_data_o, rsp_err_o : per-channel read data / one-cycle error pulse
//   stall_req_o           : per-channel stall request to ctrl
//   wb_*                  : Wishbone classic master
// Optional: define WB_RMW_EN to turn partial-select writes into full-word
// read-modify-write sequences for slaves without byte selects.
module wb_multi_arbiter
  import wb_multi_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = DATA_W / 8,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [NUM_CH-1:0]          req_ce_i,
  input  logic [NUM_CH-1:0]          req_we_i,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   req_data_i,
  input  logic [NUM_CH*SEL_W-1:0]    req_sel_i,
  output logic [NUM_CH*DATA_W-1:0]   rsp_data_o,
  output logic [NUM_CH-1:0]          rsp_err_o,
  output logic [NUM_CH-1:0]          stall_req_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [ADDR_W-1:0]          wb_adr_o,
  output logic [DATA_W-1:0]          wb_dat_o,
  output logic [SEL_W-1:0]           wb_sel_o,
  input  logic [DATA_W-1:0]          wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t               state_q, state_d;
  logic [IDX_W-1:0]         gnt_q, enc_idx;
  logic                     enc_valid;
  logic [NUM_CH-1:0]        req_mask, done_q;
  logic                     cancel_q, cancel_d;
  logic [TMO_W-1:0]         tmo_q;
  logic                     cyc_q, we_q;
  logic [ADDR_W-1:0]        adr_q;
  logic [DATA_W-1:0]        dat_q, merged;
  logic [SEL_W-1:0]         sel_q;
  logic [NUM_CH*DATA_W-1:0] rsp_data_q;
  logic [NUM_CH-1:0]        rsp_err_q;
  logic                     tmo_hit, bus_err, term, rmw_start;

  // flush blocks a channel-0 grant in the same cycle
  assign req_mask = req_ce_i & ~done_q & ~NUM_CH'(flush_i);

  wb_prio_enc #(.N(NUM_CH), .IDX_W(IDX_W)) u_prio_enc (
    .req   (req_mask),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign bus_err  = wb_err_i | tmo_hit;
  assign term     = wb_ack_i | bus_err;
  // a flush arriving in the completion cycle still cancels the response
  assign cancel_d = cancel_q | (flush_i && (gnt_q == '0));

`ifdef WB_RMW_EN
  localparam logic [SEL_W-1:0] SEL_ALL = WB_SEL_ALL[SEL_W-1:0];
  assign rmw_start = req_we_i[enc_idx] && (req_sel_i[enc_idx*SEL_W +: SEL_W] != SEL_ALL);
  assign wb_sel_o  = (state_q == ST_RMW_RD || state_q == ST_RMW_WR) ? SEL_ALL : sel_q;
  assign wb_we_o   = we_q && (state_q != ST_RMW_RD);
`else
  assign rmw_start = 1'b0;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
`endif

  always_comb begin
    merged = wb_dat_i;
    for (int unsigned b = 0; b < SEL_W; b++) begin
      if (sel_q[b]) merged[b*8 +: 8] = dat_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enc_valid) state_d = rmw_start ? ST_RMW_RD : ST_BUS;
      ST_BUS:    if (term) state_d = ST_DONE;
      ST_RMW_RD: if (bus_err) state_d = ST_DONE;
                 else if (wb_ack_i) state_d = ST_RMW_WR;
      ST_RMW_WR: if (term) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      cancel_q   <= 1'b0;
      tmo_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= '0;
    end else begin
      state_q   <= state_d;
      rsp_err_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (enc_valid) begin
            gnt_q <= enc_idx;
            we_q  <= req_we_i[enc_idx];
            adr_q <= req_addr_i[enc_idx*ADDR_W +: ADDR_W];
            dat_q <= req_data_i[enc_idx*DATA_W +: DATA_W];
            sel_q <= req_sel_i[enc_idx*SEL_W +: SEL_W];
            cyc_q <= 1'b1;
            tmo_q <= '0;
          end
        end
        ST_BUS, ST_RMW_RD, ST_RMW_WR: begin
          cancel_q <= cancel_d;
          if (tmo_q != TMO_W'(TIMEOUT)) tmo_q <= tmo_q + 1'b1;
          if (term) begin
            if (state_q == ST_RMW_RD && !bus_err) begin
              // read phase done: keep cyc, restart timeout for the write phase
              dat_q <= merged;
              tmo_q <= '0;
            end else begin
              cyc_q         <= 1'b0;
              done_q[gnt_q] <= 1'b1;
              if (!cancel_d) begin
                if (bus_err) rsp_err_q[gnt_q] <= 1'b1;
                else if (!we_q) rsp_data_q[gnt_q*DATA_W +: DATA_W] <= wb_dat_i;
              end
            end
          end
        end
        ST_DONE: begin
          cancel_q <= 1'b0;
          done_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      stall_req_o[i] = req_ce_i[i] ? STOP : NO_STOP;
      if (state_q == ST_DONE && gnt_q == IDX_W'(i) && !cancel_q) stall_req_o[i] = NO_STOP;
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_wb_multi_arbiter.sv
module tb_wb_multi_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NCH-1:0]    req_ce, req_we;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_data;
  logic [NCH*SW-1:0] req_sel;
  logic [NCH*DW-1:0] rsp_data_o;
  logic [NCH-1:0]    rsp_err_o, stall_req_o;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]     wb_adr_o;
  logic [DW-1:0]     wb_dat_o;
  logic [SW-1:0]     wb_sel_o;
  logic [DW-1:0]     wb_dat_i = '0;
  logic              wb_ack_i = 1'b0;
  logic              wb_err_i = 1'b0;

  wb_multi_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .req_ce_i(req_ce), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_sel_i(req_sel),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .stall_req_o(stall_req_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } sb_t;

  sb_t         sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [DW-1:0] exp_rsp [NCH];

  // slave model: responds slave_lat cycles after a phase starts (-1 = never)
  int          slave_lat = 1;
  logic        slave_err = 1'b0;
  logic [DW-1:0] slave_mem = '0;
  int          cnt = 0;

  always @(negedge clk) begin
    logic resp;
    sb_t  e;
    if (!wb_cyc_o) cnt = 0;
    else if (wb_ack_i || wb_err_i) cnt = 1;
    else cnt = cnt + 1;
    resp = wb_cyc_o && wb_stb_o && slave_lat >= 0 && cnt == slave_lat + 1;
    wb_ack_i = resp && !slave_err;
    wb_err_i = resp && slave_err;
    wb_dat_i = (resp && !wb_we_o) ? slave_mem : '0;
    if (resp) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: unexpected bus phase adr=%h we=%b", wb_adr_o, wb_we_o);
      end else begin
        e = sb_q.pop_front();
        if ({wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o} !== {e.adr, e.we, e.dat, e.sel}) begin
          n_bad++;
          $display("FAIL sb_bus: got adr=%h we=%b dat=%h sel=%h, want adr=%h we=%b dat=%h sel=%h",
                   wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o, e.adr, e.we, e.dat, e.sel);
        end
      end
      if (wb_ack_i && wb_we_o) begin
        for (int b = 0; b < SW; b++)
          if (wb_sel_o[b]) slave_mem[b*8 +: 8] = wb_dat_o[b*8 +: 8];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    req_ce[ch]             = 1'b1;
    req_we[ch]             = we;
    req_addr[ch*AW +: AW]  = adr;
    req_data[ch*DW +: DW]  = dat;
    req_sel[ch*SW +: SW]   = sel;
  endtask

  task automatic push(input logic [AW-1:0] adr, input logic we,
                      input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    sb_t e;
    e.adr = adr; e.we = we; e.dat = dat; e.sel = sel;
    sb_q.push_back(e);
  endtask

  // run until channel ch sees its stall released; then drop its request
  task automatic serve(input int ch, input int budget, output int cyc_n,
                       output int err_n, output bit rel);
    cyc_n = 0; err_n = 0; rel = 1'b0;
    for (int k = 0; k < budget && !rel; k++) begin
      step();
      if (wb_cyc_o) cyc_n++;
      if (rsp_err_o[ch]) err_n++;
      if (!stall_req_o[ch]) begin
        rel = 1'b1;
        req_ce[ch] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    req_ce = '0; req_we = '0; req_addr = '0; req_data = '0; req_sel = '0;
    step(); step();
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, rsp_err_o, stall_req_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: cyc=%b stb=%b adr=%h err=%b stall=%b, want all 0",
               wb_cyc_o, wb_stb_o, wb_adr_o, rsp_err_o, stall_req_o);
    end
    n_cmp++;
    if (rsp_data_o !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp: got %h want 0", rsp_data_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    int cn, en; bit rel;
    slave_lat = 2; slave_mem = 32'hDEADBEEF;
    drive(0, 1'b0, 32'h8000_0010, '0, 4'hF);
    push(32'h8000_0010, 1'b0, '0, 4'hF);
    serve(0, 20, cn, en, rel);
    exp_rsp[0] = 32'hDEADBEEF;
    n_cmp++;
    if (!rel) begin n_bad++; $display("FAIL single_release: stall never dropped"); end
    n_cmp++;
    if (cn !== 3) begin n_bad++; $display("FAIL single_cyc_len: got %0d want 3", cn); end
    n_cmp++;
    if (rsp_data_o[0 +: DW] !== exp_rsp[0]) begin
      n_bad++; $display("FAIL single_data: got %h want %h", rsp_data_o[0 +: DW], exp_rsp[0]);
    end
    n_cmp++;
    if (en !== 0) begin n_bad++; $display("FAIL single_err: got %0d pulses want 0", en); end
    step();
  endtask

  task automatic test_priority();
    bit rel1, rel0, ok_order;
    int k;
    slave_lat = 1;
    drive(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF);
    drive(0, 1'b0, 32'h0000_0200, '0, 4'hF);
    push(32'h0000_0100, 1'b1, 32'h1234_5678, 4'hF);
    push(32'h0000_0200, 1'b0, '0, 4'hF);
    rel1 = 1'b0; rel0 = 1'b0; ok_order = 1'b1; k = 0;
    while (!rel0 && k < 40) begin
      step(); k++;
      if (!rel1 && stall_req_o[0] !== 1'b1) ok_order = 1'b0;
      if (!rel1 && !stall_req_o[1]) begin rel1 = 1'b1; req_ce[1] = 1'b0; end
      else if (!stall_req_o[0]) begin rel0 = 1'b1; req_ce[0] = 1'b0; end
    end
    exp_rsp[0] = 32'h1234_5678;
    n_cmp++;
    if (!(rel1 && rel0 && ok_order)) begin
      n_bad++; $display("FAIL prio_order: rel1=%b rel0=%b ch0_held=%b want 1 1 1", rel1, rel0, ok_order);
    end
    n_cmp++;
    if (rsp_data_o[0 +: DW] !== exp_rsp[0]) begin
      n_bad++; $display("FAIL prio_ch0_data: got %h want %h", rsp_data_o[0 +: DW], exp_rsp[0]);
    end
    step();
  endtask

  task automatic test_flush();
    int k;
    slave_lat = 2; slave_mem = 32'hCAFEF00D;
    flush = 1'b1;
    drive(0, 1'b0, 32'h8000_0040, '0, 4'hF);
    step(); step();
    n_cmp++;
    if (wb_cyc_o !== 1'b0) begin n_bad++; $display("FAIL flush_idle_grant: cyc=%b want 0", wb_cyc_o); end
    flush = 1'b0;
    push(32'h8000_0040, 1'b0, '0, 4'hF);
    step();
    n_cmp++;
    if (wb_cyc_o !== 1'b1) begin n_bad++; $display("FAIL flush_grant_after: cyc=%b want 1", wb_cyc_o); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    k = 0;
    while (wb_cyc_o && k < 20) begin step(); k++; end
    n_cmp++;
    if ({stall_req_o[0], rsp_err_o[0]} !== 2'b10) begin
      n_bad++; $display("FAIL flush_done: stall=%b err=%b want stall=1 err=0", stall_req_o[0], rsp_err_o[0]);
    end
    n_cmp++;
    if (rsp_data_o[0 +: DW] !== exp_rsp[0]) begin
      n_bad++; $display("FAIL flush_data: got %h want %h", rsp_data_o[0 +: DW], exp_rsp[0]);
    end
    req_ce[0] = 1'b0;
    step(); step();
    n_cmp++;
    if (wb_cyc_o !== 1'b0) begin n_bad++; $display("FAIL flush_regrant: cyc=%b want 0", wb_cyc_o); end
  endtask

  task automatic test_bus_err();
    int cn, en; bit rel;
    slave_lat = 1; slave_err = 1'b1;
    drive(1, 1'b0, 32'h0000_0300, '0, 4'hF);
    push(32'h0000_0300, 1'b0, '0, 4'hF);
    serve(1, 20, cn, en, rel);
    slave_err = 1'b0;
    n_cmp++;
    if (!rel || en !== 1) begin n_bad++; $display("FAIL err_pulse: rel=%b pulses=%0d want 1/1", rel, en); end
    step();
    n_cmp++;
    if (rsp_err_o !== '0) begin n_bad++; $display("FAIL err_width: err=%b want 0 after one cycle", rsp_err_o); end
    n_cmp++;
    if (rsp_data_o[DW +: DW] !== exp_rsp[1]) begin
      n_bad++; $display("FAIL err_data: got %h want %h", rsp_data_o[DW +: DW], exp_rsp[1]);
    end
  endtask

  task automatic test_timeout();
    int cn, en; bit rel;
    slave_lat = -1;
    drive(1, 1'b0, 32'h0000_0400, '0, 4'hF);
    serve(1, 30, cn, en, rel);
    n_cmp++;
    if (!rel || cn !== 8 || en !== 1) begin
      n_bad++; $display("FAIL timeout: rel=%b cyc_cycles=%0d pulses=%0d want 1/8/1", rel, cn, en);
    end
    n_cmp++;
    if (wb_cyc_o !== 1'b0) begin n_bad++; $display("FAIL timeout_cyc: cyc=%b want 0", wb_cyc_o); end
    step();
  endtask

  task automatic test_reset_mid();
    int errs;
    slave_lat = -1;
    drive(1, 1'b0, 32'h0000_0500, '0, 4'hF);
    step(); step(); step();
    rst = 1'b1; req_ce = '0;
    step();
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin
      n_bad++; $display("FAIL rst_mid_cyc: cyc=%b stb=%b want 0 0", wb_cyc_o, wb_stb_o);
    end
    rst = 1'b0;
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_err_o !== '0 || wb_cyc_o) errs++;
    end
    n_cmp++;
    if (errs !== 0) begin n_bad++; $display("FAIL rst_mid_quiet: %0d active cycles want 0", errs); end
  endtask

`ifdef WB_RMW_EN
  task automatic test_rmw();
    int cn, en; bit rel;
    slave_lat = 1; slave_mem = 32'hAABBCCDD;
    drive(1, 1'b1, 32'h0000_0600, 32'h0000_00EE, 4'h1);
    push(32'h0000_0600, 1'b0, 32'h0000_00EE, 4'hF);
    push(32'h0000_0600, 1'b1, 32'hAABBCCEE, 4'hF);
    serve(1, 30, cn, en, rel);
    n_cmp++;
    if (!rel || en !== 0 || cn !== 4) begin
      n_bad++; $display("FAIL rmw_seq: rel=%b pulses=%0d cyc_cycles=%0d want 1/0/4", rel, en, cn);
    end
    n_cmp++;
    if (slave_mem !== 32'hAABBCCEE) begin
      n_bad++; $display("FAIL rmw_mem: got %h want aabbccee", slave_mem);
    end
    step();
  endtask
`endif

  initial begin
    exp_rsp[0] = '0;
    exp_rsp[1] = '0;
    test_reset();
    test_single_read();
    test_priority();
    test_flush();
    test_bus_err();
    test_timeout();
    test_reset_mid();
`ifdef WB_RMW_EN
    test_rmw();
`endif
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_bad++; $display("FAIL sb_leftover: %0d expected bus phases never seen", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
